uart_rx_fifo: RTL and testbench

// - 8N1 UART receiver with a show-ahead receive FIFO; upstream source for the SFR serial-in register.
// - The SFR reads the FIFO head on rd_data and pulses pop once per consumed byte.
// - Error flags are sticky; the SFR clears them through clr_err.
// - Makes the CPU's UART link bidirectional alongside the existing serial transmitter.

---
 rtl/sfr_pkg.sv | 15 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// Shared definitions for the SFR-attached serial peripherals.
package sfr_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam logic [7:0] SOUT_ADDR = 8'h10;
    localparam logic [7:0] SIN_ADDR  = SOUT_ADDR + 8'd1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head is presented on rd_data and reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO, with sticky overrun and framing-error flags.
module uart_rx_fifo
    import sfr_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        uart_rx,
    input  logic                        pop,
    input  logic                        clr_err,
    output logic [7:0]                  rd_data,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overrun,
    output logic                        frame_err
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          shift_en;
    logic          push;
    logic          frame_set;
    logic          fifo_full;
    logic          overrun_set;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Restarting on state entry lines every sample point up with the mid-start sample.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            bit_cnt <= '0;
        else if (state_next != state || bit_cnt == LAST)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= RX_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        push       = 1'b0;
        frame_set  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s)
                    state_next = RX_START;
            end
            RX_START: begin
                if (bit_cnt == HALF)
                    state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_cnt == LAST) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7)
                        state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_cnt == LAST) begin
                    push       = rx_s;
                    frame_set  = !rx_s;
                    state_next = rx_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_s)
                    state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state != RX_DATA)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;
            if (shift_en)
                shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    assign overrun_set = push && fifo_full && !pop;

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
            if (frame_set)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (push),
        .pop     (pop),
        .wr_data (shift_reg),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

    logic       clk;
    logic       nrst;
    logic       uart_rx;
    logic       pop;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic       pre_empty;
    logic [7:0] post_data;
    logic [2:0] post_count;
    logic       post_empty;

    uart_rx_fifo #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .uart_rx   (uart_rx),
        .pop       (pop),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stop-bit sample lands 12 clocks into the stop bit; snapshots bracket that edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic pop_on_push);
        tick;
        uart_rx = 1'b0;
        repeat (16) tick;
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (16) tick;
        end
        uart_rx = stop_bit;
        repeat (11) tick;
        pre_empty = empty;
        if (pop_on_push)
            pop = 1'b1;
        tick;
        pop        = 1'b0;
        post_data  = rd_data;
        post_count = count;
        post_empty = empty;
        repeat (4) tick;
    endtask

    task automatic pop_byte;
        pop = 1'b1;
        tick;
        pop = 1'b0;
    endtask

    task automatic clear_flags;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        nrst    = 1'b0;
        uart_rx = 1'b1;
        pop     = 1'b0;
        clr_err = 1'b0;
        repeat (3) tick;
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected %h", rd_data, 8'h00); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        nrst = 1'b1;
        repeat (5) tick;
    endtask

    task automatic test_single_byte;
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if (pre_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_pre_empty: got %b expected 1", pre_empty); end
        checks++;
        if (post_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", post_data, 8'hA5); end
        checks++;
        if (post_count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", post_count); end
        checks++;
        if (post_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty: got %b expected 0", post_empty); end
        pop_byte;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL single_pop_empty: got %b expected 1", empty); end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL single_pop_data: got %h expected 00", rd_data); end
        pop_byte;
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL pop_empty_count: got %0d expected 0", count); end
    endtask

    task automatic test_glitch;
        tick;
        uart_rx = 1'b0;
        repeat (8) tick;
        uart_rx = 1'b1;
        repeat (40) tick;
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL glitch_count: got %0d expected 0", count); end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL glitch_flags: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        send_frame(8'h3E, 1'b1, 1'b0);
        checks++;
        if (post_data !== 8'h3E || post_count !== 3'd1) begin errors++; $display("[TB] FAIL glitch_recover: got %h/%0d expected 3e/1", post_data, post_count); end
        pop_byte;
    endtask

    task automatic test_overrun;
        logic [7:0] bytes [5];
        logic [7:0] heads [3];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        heads = '{8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 5; i++)
            send_frame(bytes[i], 1'b1, 1'b0);
        checks++;
        if (count !== 3'd4) begin errors++; $display("[TB] FAIL overrun_count: got %0d expected 4", count); end
        checks++;
        if (rd_data !== 8'h11) begin errors++; $display("[TB] FAIL overrun_head: got %h expected 11", rd_data); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", overrun); end
        for (int i = 0; i < 3; i++) begin
            pop_byte;
            checks++;
            if (rd_data !== heads[i]) begin errors++; $display("[TB] FAIL overrun_pop%0d: got %h expected %h", i, rd_data, heads[i]); end
        end
        pop_byte;
        checks++;
        if (empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL overrun_drain: got empty=%b data=%h expected 1 00", empty, rd_data); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); end
        clear_flags;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_error;
        send_frame(8'h3C, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL frame_err_set: got %b expected 1", frame_err); end
        checks++;
        if (post_count !== 3'd0) begin errors++; $display("[TB] FAIL frame_discard: got %0d expected 0", post_count); end
        repeat (300) tick;
        clear_flags;
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL frame_err_clear: got %b expected 0", frame_err); end
        repeat (340) tick;
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL frame_err_once: got %b expected 0", frame_err); end
        uart_rx = 1'b1;
        repeat (20) tick;
        send_frame(8'h5A, 1'b1, 1'b0);
        checks++;
        if (post_data !== 8'h5A || post_count !== 3'd1) begin errors++; $display("[TB] FAIL frame_next_byte: got %h/%0d expected 5a/1", post_data, post_count); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL frame_clean: got %b expected 0", frame_err); end
        pop_byte;
    endtask

    task automatic test_full_push_pop;
        logic [7:0] heads [3];
        heads = '{8'h03, 8'h04, 8'h05};
        for (int i = 1; i <= 4; i++)
            send_frame(8'(i), 1'b1, 1'b0);
        checks++;
        if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        send_frame(8'h05, 1'b1, 1'b1);
        checks++;
        if (post_count !== 3'd4) begin errors++; $display("[TB] FAIL pushpop_count: got %0d expected 4", post_count); end
        checks++;
        if (post_data !== 8'h02) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected 02", post_data); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overrun: got %b expected 0", overrun); end
        for (int i = 0; i < 3; i++) begin
            pop_byte;
            checks++;
            if (rd_data !== heads[i]) begin errors++; $display("[TB] FAIL pushpop_pop%0d: got %h expected %h", i, rd_data, heads[i]); end
        end
        pop_byte;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_drain: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h77, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd1) begin errors++; $display("[TB] FAIL midrst_pre_count: got %0d expected 1", count); end
        tick;
        uart_rx = 1'b0;
        repeat (16) tick;
        uart_rx = 1'b1;
        repeat (16) tick;
        uart_rx = 1'b0;
        repeat (8) tick;
        nrst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_fifo: got count=%0d empty=%b data=%h expected 0 1 00", count, empty, rd_data); end
        checks++;
        if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got ov=%b fe=%b expected 0 0", overrun, frame_err); end
        uart_rx = 1'b1;
        repeat (3) tick;
        nrst = 1'b1;
        repeat (40) tick;
        send_frame(8'h96, 1'b1, 1'b0);
        checks++;
        if (post_data !== 8'h96 || post_count !== 3'd1) begin errors++; $display("[TB] FAIL midrst_next: got %h/%0d expected 96/1", post_data, post_count); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_glitch;
        test_overrun;
        test_frame_error;
        test_full_push_pop;
        test_reset_mid_frame;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
